// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready front end sharing one combinational ALU
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 wins every tie).
module alu_arbiter #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_srca0,
    input  logic [WIDTH-1:0] req_srcb0,
    input  logic [2:0]       req_ctl0,
    input  logic [WIDTH-1:0] req_srca1,
    input  logic [WIDTH-1:0] req_srcb1,
    input  logic [2:0]       req_ctl1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             grant;
    logic [WIDTH-1:0] aluout;

    // Winner among the valid requesters; only meaningful when req_valid != 0.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_comb begin
        case (ctl_q)
            3'b010:  aluout = srca_q + srcb_q;
            3'b110:  aluout = srca_q - srcb_q;
            3'b000:  aluout = srca_q & srcb_q;
            3'b001:  aluout = srca_q | srcb_q;
            3'b111:  aluout = {{(WIDTH-1){1'b0}}, (srca_q < srcb_q)};
            3'b011:  aluout = srcb_q << srca_q[4:0];
            3'b100:  aluout = srcb_q >> srca_q[4:0];
            3'b101:  aluout = $signed(srcb_q) >>> srca_q[4:0];
            default: aluout = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        ctl_d        = ctl_q;
        rsp_data_d   = rsp_data_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready    = grant ? 2'b10 : 2'b01;
                    owner_d      = grant;
                    last_grant_d = grant;
                    srca_d       = grant ? req_srca1 : req_srca0;
                    srcb_d       = grant ? req_srcb1 : req_srcb0;
                    ctl_d        = grant ? req_ctl1 : req_ctl0;
                    cnt_d        = CNT_INIT;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d = aluout;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ready path is combinational, so hold it low while reset is asserted.
        if (!resetn) begin
            req_ready = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            srca_q       <= '0;
            srcb_q       <= '0;
            ctl_q        <= 3'b000;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            ctl_q        <= ctl_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized bench for alu_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn    [2];
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [31:0] srca0     [2];
    logic [31:0] srcb0     [2];
    logic [2:0]  ctl0      [2];
    logic [31:0] srca1     [2];
    logic [31:0] srcb1     [2];
    logic [2:0]  ctl1      [2];
    logic [1:0]  rsp_valid [2];
    logic [1:0]  rsp_ready [2];
    logic [31:0] rsp_data  [2];

    alu_arbiter #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .resetn(resetn[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_srca0(srca0[0]), .req_srcb0(srcb0[0]), .req_ctl0(ctl0[0]),
        .req_srca1(srca1[0]), .req_srcb1(srcb1[0]), .req_ctl1(ctl1[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0])
    );

    alu_arbiter #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .resetn(resetn[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_srca0(srca0[1]), .req_srcb0(srcb0[1]), .req_ctl0(ctl0[1]),
        .req_srca1(srca1[1]), .req_srcb1(srcb1[1]), .req_ctl1(ctl1[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1])
    );

    int          checks = 0;
    int          failures = 0;
    op_t         q0[$];
    op_t         q1[$];
    int          grants[$];
    logic [31:0] rsp_log[$];
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_acc;
    logic [31:0] m_res;
    int          cyc;
    bit          rr_rand;
    logic [1:0]  rr_pat;
    bit          fixed_prio;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        op_t o;
        o.a = a;
        o.b = b;
        o.c = c;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.c = 3'($urandom_range(0, 7));
        o.b = $urandom();
        case ($urandom_range(0, 2))
            0:       o.a = $urandom();
            1:       o.a = o.b;
            default: o.a = 32'($urandom_range(0, 40));
        endcase
        if (o.c == 3'b011 || o.c == 3'b100 || o.c == 3'b101) o.a = 32'($urandom_range(0, 31));
        return o;
    endfunction

    function automatic logic [31:0] alu_ref(input op_t o);
        case (o.c)
            3'b010:  return o.a + o.b;
            3'b110:  return o.a - o.b;
            3'b000:  return o.a & o.b;
            3'b001:  return o.a | o.b;
            3'b111:  return (o.a < o.b) ? 32'd1 : 32'd0;
            3'b011:  return o.b << o.a[4:0];
            3'b100:  return o.b >> o.a[4:0];
            3'b101:  return 32'($signed(o.b) >>> o.a[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (rsp_log.size() > i) ? rsp_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int grant_at(input int i);
        return (grants.size() > i) ? grants[i] : -1;
    endfunction

    function automatic bit in_resp(input int k);
        return m_busy && (cyc >= m_acc + lat_of(k) + 1);
    endfunction

    // One clock of instance k: present queue heads, then check against the model.
    task automatic step(input int k);
        logic [1:0] rdy_exp;
        logic [1:0] vld_exp;
        logic [1:0] rr;
        op_t        h0;
        op_t        h1;
        int         g;
        @(negedge clk);
        cyc++;
        h0 = (q0.size() > 0) ? q0[0] : rand_op();
        h1 = (q1.size() > 0) ? q1[0] : rand_op();
        req_valid[k] = {q1.size() > 0, q0.size() > 0};
        srca0[k] = h0.a; srcb0[k] = h0.b; ctl0[k] = h0.c;
        srca1[k] = h1.a; srcb1[k] = h1.b; ctl1[k] = h1.c;
        rr = rr_rand ? 2'($urandom()) : rr_pat;
        rsp_ready[k] = rr;
        #1;
        g = -1;
        rdy_exp = 2'b00;
        if (!m_busy && req_valid[k] != 2'b00) begin
            if (req_valid[k] == 2'b01)      g = 0;
            else if (req_valid[k] == 2'b10) g = 1;
            else                            g = (fixed_prio || m_last == 1) ? 0 : 1;
            rdy_exp = (g == 0) ? 2'b01 : 2'b10;
        end
        check_eq("req_ready", 32'(req_ready[k]), 32'(rdy_exp));
        vld_exp = 2'b00;
        if (in_resp(k)) vld_exp = (m_owner == 0) ? 2'b01 : 2'b10;
        check_eq("rsp_valid", 32'(rsp_valid[k]), 32'(vld_exp));
        if (vld_exp != 2'b00) begin
            check_eq("rsp_data", rsp_data[k], m_res);
            if (rr[m_owner]) begin
                m_busy = 1'b0;
                rsp_log.push_back(rsp_data[k]);
            end
        end else if (g >= 0) begin
            m_busy  = 1'b1;
            m_owner = g;
            m_last  = g;
            m_acc   = cyc;
            grants.push_back(g);
            if (g == 0) m_res = alu_ref(q0.pop_front());
            else        m_res = alu_ref(q1.pop_front());
        end
    endtask

    task automatic drain(input int k, input int budget);
        int n;
        n = 0;
        while ((m_busy || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step(k);
            n++;
        end
        check_eq("drain", 32'(int'(m_busy) + q0.size() + q1.size()), 32'd0);
    endtask

    task automatic clear_model();
        m_busy = 1'b0;
        m_last = 1;
        grants.delete();
        rsp_log.delete();
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        resetn[k]    = 1'b0;
        req_valid[k] = 2'b11;
        #1;
        check_eq("rst_req_ready", 32'(req_ready[k]), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        check_eq("rst_rsp_data", rsp_data[k], 32'd0);
        @(negedge clk);
        req_valid[k] = 2'b00;
        resetn[k]    = 1'b1;
        clear_model();
    endtask

    task automatic random_phase(input int k, input int ncyc);
        rr_rand = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 1) == 1) q0.push_back(rand_op());
            if (q1.size() == 0 && $urandom_range(0, 1) == 1) q1.push_back(rand_op());
            step(k);
        end
        rr_rand = 1'b0;
        rr_pat  = 2'b11;
        drain(k, 40);
    endtask

    initial begin
        int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            resetn[k] = 1'b0; req_valid[k] = 2'b00; rsp_ready[k] = 2'b00;
            srca0[k] = '0; srcb0[k] = '0; ctl0[k] = '0;
            srca1[k] = '0; srcb1[k] = '0; ctl1[k] = '0;
        end
        rr_rand = 1'b0;
        rr_pat  = 2'b11;
        cyc     = 0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("init_req_ready", 32'(req_ready[k]), 32'd0);
            check_eq("init_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check_eq("init_rsp_data", rsp_data[k], 32'd0);
        end
        @(negedge clk);
        resetn[0] = 1'b1;
        resetn[1] = 1'b1;

        // LATENCY=1 instance
        step(0);
        q0.push_back(mk(32'd5, 32'd7, 3'b010));
        rr_pat = 2'b01;
        drain(0, 20);
        check_eq("add_5_7", log_at(0), 32'd12);

        pulse_reset(0);
        rr_pat = 2'b11;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(32'd3, 32'd1, 3'b110));
            q1.push_back(mk(32'hF0, 32'h0F, 3'b001));
        end
        drain(0, 60);
        check_eq("tie_grant0", 32'(grant_at(0)), 32'd0);
        check_eq("tie_grant1", 32'(grant_at(1)), fixed_prio ? 32'd0 : 32'd1);
        check_eq("tie_grant2", 32'(grant_at(2)), 32'd0);
        check_eq("tie_res0", log_at(0), 32'd2);
        check_eq("tie_res1", log_at(1), fixed_prio ? 32'd2 : 32'hFF);
        check_eq("tie_res2", log_at(2), 32'd2);

        rsp_log.delete();
        q1.push_back(mk(32'd4, 32'd1, 3'b011));
        drain(0, 20);
        check_eq("shl", log_at(0), 32'd16);
        rsp_log.delete();
        q0.push_back(mk(32'd1, 32'hFFFF_FFFF, 3'b111));
        drain(0, 20);
        check_eq("sltu", log_at(0), 32'd1);

        // Owner 0 held in RESP; the non-owner's ready must be ignored.
        rr_pat = 2'b10;
        q0.push_back(rand_op());
        n = 0;
        while (!m_busy && n < 10) begin step(0); n++; end
        q1.push_back(rand_op());
        n = 0;
        while (!in_resp(0) && n < 10) begin step(0); n++; end
        check_eq("hold_reached", 32'(in_resp(0)), 32'd1);
        repeat (5) step(0);
        check_eq("hold_valid", 32'(rsp_valid[0]), 32'b01);
        rr_pat = 2'b11;
        drain(0, 30);

        random_phase(0, 300);

        // LATENCY=3 instance
        clear_model();
        rr_pat = 2'b11;
        q0.push_back(mk(32'd100, 32'd23, 3'b010));
        q1.push_back(mk(32'h8000_0000, 32'd4, 3'b101));
        n = 0;
        while (!m_busy && n < 10) begin step(1); n++; end
        step(1);
        pulse_reset(1);
        q0.push_back(mk(32'd9, 32'd9, 3'b110));
        drain(1, 40);
        check_eq("post_rst_tie", 32'(grant_at(0)), 32'd0);
        check_eq("post_rst_count", 32'(rsp_log.size()), 32'd2);

        random_phase(1, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
